fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC register and feeding the IF/ID pipeline boundary. Each cycle it reads the 16-bit instruction-memory word addressed by the current PC and assembles 16-bit or 32-bit (opcode + immediate) instructions. It drives the PC's next value and write enable, and registers the assembled instruction into the IF/ID outputs. It also handles stall and taken-branch redirect.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the PC register and IF/ID.
// Reads one 16-bit word per cycle from the word at pc. A word with bit 15
// set is an opcode whose immediate follows in the next word, so the two
// words are joined into one 32-bit instruction. Handles stall and
// taken-branch redirect, and drives the PC register's next value and write
// enable combinationally.
//
// state | meaning
// ------+---------------------------------------------------------------
// S_OP  | expecting an opcode word (16-bit instr or first half of 32-bit)
// S_IMM | opcode held in op_word_q/op_pc_q, expecting its immediate word
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     pc_i,
  input  logic [WORD_W-1:0]     imem_data_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_W-1:0]     redirect_target_i,
  output logic [ADDR_W-1:0]     pc_next_o,
  output logic                  pc_we_o,
  output logic [2*WORD_W-1:0]   ifid_instr_o,
  output logic [ADDR_W-1:0]     ifid_pc_o,
  output logic                  ifid_valid_o
);

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     op_word_q, op_word_d;
  logic [ADDR_W-1:0]     op_pc_q, op_pc_d;
  logic [2*WORD_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]     ifid_pc_q, ifid_pc_d;
  logic                  ifid_valid_q, ifid_valid_d;

  logic [ADDR_W-1:0]     pc_inc;
  logic                  is_long;

  // pc+1 wraps silently at the top of the address space.
  assign pc_inc  = pc_i + ADDR_W'(1);
  assign is_long = imem_data_i[WORD_W-1];

  // Next-state, hold-register and PC-control decode; priority is
  // reset > redirect > stall > normal fetch.
  always_comb begin
    state_d      = state_q;
    op_word_d    = op_word_q;
    op_pc_d      = op_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    pc_we_o      = 1'b0;
    pc_next_o    = pc_inc;

    if (!rst_i) begin
      // The PC register applies its own reset value; keep it unwritten.
      pc_we_o = 1'b0;
    end else if (redirect_i) begin
      // A pending opcode belongs to the squashed path, so it is dropped.
      pc_we_o      = 1'b1;
      pc_next_o    = redirect_target_i;
      ifid_valid_d = 1'b0;
      state_d      = S_OP;
    end else if (stall_i) begin
      pc_we_o = 1'b0;
    end else begin
      pc_we_o = 1'b1;
      unique case (state_q)
        S_OP: begin
          if (is_long) begin
            op_word_d    = imem_data_i;
            op_pc_d      = pc_i;
            ifid_valid_d = 1'b0;
            state_d      = S_IMM;
          end else begin
            ifid_instr_d = {imem_data_i, {WORD_W{1'b0}}};
            ifid_pc_d    = pc_i;
            ifid_valid_d = 1'b1;
          end
        end
        S_IMM: begin
          ifid_instr_d = {op_word_q, imem_data_i};
          ifid_pc_d    = op_pc_q;
          ifid_valid_d = 1'b1;
          state_d      = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  // State, hold registers and IF/ID boundary, with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_OP;
      op_word_q    <= '0;
      op_pc_q      <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_word_q    <= op_word_d;
      op_pc_q      <= op_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized stimulus for fetch_unit, checked
// against a behavioural model that tracks "is an opcode pending" and the
// expected IF/ID contents directly from the instruction-format rules.
module tb_fetch_unit;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] pc_i;
  logic [15:0] imem_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] pc_next_o;
  logic        pc_we_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic        ifid_valid_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model state
  bit          m_pend;
  logic [15:0] m_pend_word;
  logic [31:0] m_pend_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;

  fetch_unit #(.ADDR_W(32), .WORD_W(16)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .pc_i              (pc_i),
    .imem_data_i       (imem_data_i),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .pc_next_o         (pc_next_o),
    .pc_we_o           (pc_we_o),
    .ifid_instr_o      (ifid_instr_o),
    .ifid_pc_o         (ifid_pc_o),
    .ifid_valid_o      (ifid_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // apply one cycle of inputs, check PC control mid-cycle, then IF/ID after the edge
  task automatic step(input logic rst, input logic stall, input logic redir,
                      input logic [31:0] target, input logic [31:0] pc,
                      input logic [15:0] data);
    logic        e_we;
    logic [31:0] e_next;
    rst_i             = rst;
    stall_i           = stall;
    redirect_i        = redir;
    redirect_target_i = target;
    pc_i              = pc;
    imem_data_i       = data;
    @(negedge clk_i);
    if (!rst)       begin e_we = 1'b0; e_next = '0; end
    else if (redir) begin e_we = 1'b1; e_next = target; end
    else if (stall) begin e_we = 1'b0; e_next = '0; end
    else            begin e_we = 1'b1; e_next = pc + 32'd1; end
    chk("pc_we", {31'b0, pc_we_o}, {31'b0, e_we});
    if (e_we) chk("pc_next", pc_next_o, e_next);
    @(posedge clk_i);
    if (!rst) begin
      m_pend = 0; m_instr = '0; m_pc = '0; m_valid = 1'b0;
    end else if (redir) begin
      m_pend = 0; m_valid = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_pend) begin
      m_instr = {m_pend_word, data}; m_pc = m_pend_pc; m_valid = 1'b1; m_pend = 0;
    end else if (data[15]) begin
      m_pend = 1; m_pend_word = data; m_pend_pc = pc; m_valid = 1'b0;
    end else begin
      m_instr = {data, 16'h0000}; m_pc = pc; m_valid = 1'b1;
    end
    #1;
    chk("ifid_valid", {31'b0, ifid_valid_o}, {31'b0, m_valid});
    chk("ifid_instr", ifid_instr_o, m_instr);
    chk("ifid_pc", ifid_pc_o, m_pc);
  endtask

  initial begin
    m_pend = 0; m_pend_word = '0; m_pend_pc = '0;
    m_instr = '0; m_pc = '0; m_valid = 1'b0;
    #2;

    // reset held two cycles with a long opcode on the bus
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd32, 16'h8ABC);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd32, 16'h8ABC);
    chk("rst_valid", {31'b0, ifid_valid_o}, 32'd0);
    chk("rst_instr", ifid_instr_o, 32'd0);

    // 16-bit stream
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd32, 16'h1234);
    chk("s16_a", ifid_instr_o, 32'h12340000);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd33, 16'h0042);
    chk("s16_b", ifid_instr_o, 32'h00420000);
    chk("s16_b_pc", ifid_pc_o, 32'd33);

    // 32-bit instruction with one bubble
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd40, 16'h8001);
    chk("s32_bubble", {31'b0, ifid_valid_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd41, 16'hBEEF);
    chk("s32_instr", ifid_instr_o, 32'h8001BEEF);
    chk("s32_pc", ifid_pc_o, 32'd40);

    // stall held three cycles in S_IMM
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd50, 16'h8001);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 32'd0, 32'd51, 16'($urandom));
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd51, 16'h00FF);
    chk("stall_instr", ifid_instr_o, 32'h800100FF);
    chk("stall_pc", ifid_pc_o, 32'd50);

    // redirect together with stall while in S_IMM
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd60, 16'h8003);
    step(1'b1, 1'b1, 1'b1, 32'd1000, 32'd61, 16'h1111);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd1000, 16'h0007);
    chk("redir_instr", ifid_instr_o, 32'h00070000);

    // PC wrap-around
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFF, 16'h0001);
    chk("wrap_pc", ifid_pc_o, 32'hFFFFFFFF);

    // reset in the middle of a 32-bit instruction
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd70, 16'h8002);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd71, 16'h9999);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd71, 16'h0005);
    chk("rst_mid_instr", ifid_instr_o, 32'h00050000);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : 32'($urandom);
      step(($urandom_range(0, 24) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           32'($urandom), rpc, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
